// File: rtl/uart_rx_fifo.sv
// Receive-side fetch engine and FWFT byte FIFO for the uart EPC wrapper.
// Define UART_RX_FIFO_ERR_DROP_EN to drop bytes captured with PE/FE/OE set.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned RDA_TIMEOUT   = 1023
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [7:0]            rx_data,
  input  logic [7:0]            rx_status,
  output logic                  uart_nCS,
  output logic                  uart_nRD,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  clr,
  output logic [2:0]            err_sticky,
  output logic                  timeout_sticky,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned SCW   = $clog2(STROBE_CYCLES);
  localparam int unsigned TOW   = $clog2(RDA_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StStrobe, StRelease, StWait} state_e;

  state_e          state_q;
  logic            strobe_n_q;
  logic [SCW-1:0]  strb_cnt_q;
  logic [TOW-1:0]  wait_cnt_q;
  logic [7:0]      data_q;
  logic [2:0]      err_q;

  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]          err_sticky_q, err_sticky_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          mem_q [Depth];

  logic rda, wait_done, push_req, timeout_hit, drop, push, pop;
  logic [DEPTH_LOG2-1:0] waddr;
  logic unused_status;

  assign rda           = rx_status[0];
  assign unused_status = ^rx_status[4:1];
  assign wait_done     = (wait_cnt_q == TOW'(RDA_TIMEOUT - 1));
  assign push_req      = (state_q == StWait) && !rda;
  assign timeout_hit   = (state_q == StWait) && rda && wait_done;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      strobe_n_q <= 1'b1;
      strb_cnt_q <= '0;
      wait_cnt_q <= '0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rda && !full) begin
            state_q    <= StStrobe;
            strobe_n_q <= 1'b0;
            strb_cnt_q <= '0;
          end
        end
        StStrobe: begin
          if (strb_cnt_q == '0) begin
            data_q <= rx_data;
            err_q  <= rx_status[7:5];
          end
          if (strb_cnt_q == SCW'(STROBE_CYCLES - 1)) begin
            state_q    <= StRelease;
            strobe_n_q <= 1'b1;
          end
          strb_cnt_q <= strb_cnt_q + SCW'(1);
        end
        StRelease: begin
          state_q    <= StWait;
          wait_cnt_q <= '0;
        end
        StWait: begin
          if (!rda || wait_done) state_q <= StIdle;
          else                   wait_cnt_q <= wait_cnt_q + TOW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_nCS = strobe_n_q;
  assign uart_nRD = strobe_n_q;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0] drop_cnt_q;
  assign drop = |err_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      drop_cnt_q <= '0;
    end else if (clr) begin
      drop_cnt_q <= '0;
    end else if (push_req && drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
  assign drop_cnt = drop_cnt_q;
`else
  assign drop     = 1'b0;
  assign drop_cnt = 8'h00;
`endif

  assign push = push_req && !drop;
  assign pop  = rd_en && !empty && !clr;
  // A push coinciding with clr lands in slot 0 of the freshly emptied FIFO.
  assign waddr = clr ? '0 : wptr_q[DEPTH_LOG2-1:0];

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    err_sticky_d = err_sticky_q;
    timeout_d    = timeout_q;
    if (clr) begin
      wptr_d       = '0;
      rptr_d       = '0;
      err_sticky_d = '0;
      timeout_d    = 1'b0;
    end else if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push)        wptr_d       = wptr_d + 1'b1;
    if (push_req)    err_sticky_d = err_sticky_d | err_q;
    if (timeout_hit) timeout_d    = 1'b1;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      err_sticky_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      err_sticky_q <= err_sticky_d;
      timeout_q    <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[waddr] <= data_q;
  end

  assign count          = wptr_q - rptr_q;
  assign empty          = (wptr_q == rptr_q);
  assign full           = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                          (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign rd_data        = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign err_sticky     = err_sticky_q;
  assign timeout_sticky = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default parameters).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       nRST;
  logic [7:0] rx_data;
  logic [7:0] rx_status;
  logic       rd_en;
  logic       clr;
  logic       uart_nCS, uart_nRD, empty, full, timeout_sticky;
  logic [7:0] rd_data, drop_cnt;
  logic [4:0] count;
  logic [2:0] err_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int low;

  uart_rx_fifo dut (
    .clk            (clk),
    .nRST           (nRST),
    .rx_data        (rx_data),
    .rx_status      (rx_status),
    .uart_nCS       (uart_nCS),
    .uart_nRD       (uart_nRD),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .clr            (clr),
    .err_sticky     (err_sticky),
    .timeout_sticky (timeout_sticky),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one byte with RDA set, measures the strobe, then drops RDA 3 clocks
  // after release; optionally pops in the same cycle as the push.
  task automatic do_fetch(input logic [7:0] d, input logic [7:0] st, input logic pop,
                          output int low_cnt);
    int   waited = 0;
    logic nrd_bad = 1'b0;
    low_cnt   = 0;
    rx_data   = d;
    rx_status = st | 8'h01;
    while (uart_nCS && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("strobe_start", uart_nCS, 1'b0);
    while (!uart_nCS && low_cnt < 20) begin
      if (uart_nRD !== uart_nCS) nrd_bad = 1'b1;
      @(negedge clk);
      low_cnt++;
    end
    check("nrd_tracks_ncs", nrd_bad, 1'b0);
    repeat (3) @(negedge clk);
    rx_status = 8'h00;
    rd_en     = pop;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   waited;
    logic strobed;
    nRST = 1'b0; rx_data = 8'h00; rx_status = 8'h00; rd_en = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ncs", uart_nCS, 1'b1);
    check("rst_nrd", uart_nRD, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_err", err_sticky, 3'b000);
    check("rst_timeout", timeout_sticky, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    nRST = 1'b1;
    @(negedge clk);

    // Single byte
    do_fetch(8'h5A, 8'h00, 1'b0, low);
    check("single_strobe_width", low, 2);
    check("single_rd_data", rd_data, 8'h5A);
    check("single_count", count, 1);
    check("single_empty", empty, 1'b0);

    // Fill to full
    pulse_clr();
    for (int i = 0; i < 16; i++) do_fetch(8'(i), 8'h00, 1'b0, low);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 16);
    check("fill_head", rd_data, 8'h00);
    rx_data   = 8'hAA;
    rx_status = 8'h01;
    strobed   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!uart_nCS) strobed = 1'b1;
    end
    check("full_no_strobe", strobed, 1'b0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_head", rd_data, 8'h01);
    check("pop_count", count, 15);
    check("pop_not_full", full, 1'b0);
    do_fetch(8'hAA, 8'h00, 1'b0, low);
    check("refill_count", count, 16);
    check("refill_head", rd_data, 8'h01);

    // Push and pop in the same cycle
    pulse_clr();
    for (int i = 0; i < 5; i++) do_fetch(8'h10 + 8'(i), 8'h00, 1'b0, low);
    check("pp_pre_count", count, 5);
    check("pp_pre_head", rd_data, 8'h10);
    do_fetch(8'h15, 8'h00, 1'b1, low);
    check("pp_count", count, 5);
    check("pp_head", rd_data, 8'h11);

    // Error byte with PE set
    pulse_clr();
    do_fetch(8'h33, 8'h80, 1'b0, low);
    check("err_sticky", err_sticky, 3'b100);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("err_count", count, 0);
    check("err_drop_cnt", drop_cnt, 8'd1);
`else
    check("err_count", count, 1);
    check("err_rd_data", rd_data, 8'h33);
    check("err_drop_cnt", drop_cnt, 8'd0);
`endif

    // RDA stuck high after a fetch
    pulse_clr();
    check("clr_err", err_sticky, 3'b000);
    do_fetch(8'h44, 8'h00, 1'b0, low);
    rx_data   = 8'h55;
    rx_status = 8'h01;
    waited    = 0;
    while (uart_nCS && waited < 20) begin @(negedge clk); waited++; end
    check("to_strobe_start", uart_nCS, 1'b0);
    waited = 0;
    while (!uart_nCS && waited < 20) begin @(negedge clk); waited++; end
    repeat (1023) @(negedge clk);
    check("to_not_yet", timeout_sticky, 1'b0);
    @(negedge clk);
    check("to_set", timeout_sticky, 1'b1);
    check("to_count", count, 1);
    rx_status = 8'h00;
    @(negedge clk);
    check("to_idle_ncs", uart_nCS, 1'b1);
    check("to_count_hold", count, 1);

    // Clear at count 7, clr beats rd_en
    for (int i = 0; i < 6; i++) do_fetch(8'h60 + 8'(i), 8'h00, 1'b0, low);
    check("pre_clr_count", count, 7);
    clr   = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    rd_en = 1'b0;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1'b1);
    check("clr_timeout", timeout_sticky, 1'b0);
    check("clr_rd_data", rd_data, 8'h00);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty_pop_count", count, 0);
    check("empty_pop_empty", empty, 1'b1);

    // Asynchronous reset during STROBE
    do_fetch(8'h01, 8'h00, 1'b0, low);
    rx_data   = 8'h77;
    rx_status = 8'h01;
    waited    = 0;
    while (uart_nCS && waited < 20) begin @(negedge clk); waited++; end
    check("rst_strobe_low", uart_nCS, 1'b0);
    #1 nRST = 1'b0;
    #1;
    check("async_ncs", uart_nCS, 1'b1);
    check("async_nrd", uart_nRD, 1'b1);
    check("async_count", count, 0);
    check("async_empty", empty, 1'b1);
    rx_status = 8'h00;
    @(negedge clk);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ncs", uart_nCS, 1'b1);
    check("post_rst_count", count, 0);
    check("post_rst_rd_data", rd_data, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
